spi_slave_cpol_cpha: RTL and testbench
======================================

# spi_slave_cpol_cpha

SPI responder (slave) for the same four-mode SPI link driven by the team's SPI master. Samples `sclk`, `cs`, `mosi` into the system clock domain, shifts in MSB-first receive words and drives MSB-first transmit words on `miso`. Supports runtime CPOL/CPHA selection and back-to-back words within one `cs` assertion. Sits between the SPI pins and a local register/FIFO interface.

## Interface
- `DATA_W`, 8: word width in bits (≥ 2).
- `clk`  in  1: system clock; all logic on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cpol`  in  1: clock polarity; idle level of `sclk`. Static while `cs` is low.
- `cpha`  in  1: 0 = sample on leading edge, 1 = sample on trailing edge. Static while `cs` is low.
- `sclk`  in  1: SPI clock from master (asynchronous to `clk`).
- `cs`  in  1: chip select, active-low (asynchronous).
- `mosi`  in  1: master-out data (asynchronous).
- `miso`  out  1: slave-out data.
- `tx_data`  in  DATA_W: next word to transmit.
- `tx_valid`  in  1: `tx_data` valid.
- `tx_ready`  out  1: holding register empty; transfer occurs when `tx_valid && tx_ready`.
- `rx_data`  out  DATA_W: last complete received word.
- `rx_valid`  out  1: one-cycle pulse, `rx_data` updated.
- `busy`  out  1: synchronized `cs` is low.
- `tx_underrun`  out  1: one-cycle pulse; see Configuration.

## Operation
- `sclk`, `cs`, `mosi` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `sclk` against its previous registered value.
- Leading edge: rising when `cpol=0`, falling when `cpol=1`. Trailing edge is the opposite one.
- Sample edge = leading if `cpha=0`, else trailing. Shift edge = the other one.
- Transmit holding register:
  - Accepts a word on `tx_valid && tx_ready`.
  - `tx_ready` deasserts until the word moves to the shift register.
- Word load happens on synchronized `cs` falling, and again after each completed word while `cs` stays low.
  - Load takes the held word if one is present; otherwise it loads all-zeros.
  - `cpha=0`: `miso` = MSB in the cycle after the load.
  - `cpha=1`: `miso` = MSB on the first shift (leading) edge. Every later shift edge presents the next bit.
- Receive path:
  - Each sample edge shifts synchronized `mosi` into the LSB of the rx shift register and increments the bit counter (0..DATA_W-1).
  - On the DATA_W-th sample: copy the register to `rx_data`, pulse `rx_valid`, clear the counter, reload tx.
- `cs` high, including mid-word abort:
  - Bit counter and shift registers clear; the partial word is discarded and no `rx_valid` is issued.
  - A word already moved to the shift register is lost. The holding register is unaffected.
- `miso` = 0 whenever synchronized `cs` is high.
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `tx_underrun`=0. Synchronizers reset to `sclk`=`cpol`, `cs`=1, `mosi`=0.
- A `tx_valid` accept and a load in the same cycle: the accepted word goes to the holding register; the load uses the prior holding content.

## Timing
- Pin-to-detect latency: 2 clk (synchronizer). Detected edge to register update: 1 clk.
- `rx_valid` pulses 3 clk after the final sample edge at the pin.
- `miso` changes 3 clk after a shift edge at the pin.
- Requirements on the master:
  - `sclk` high and low times ≥ 4 clk each.
  - `cs` low-to-first-edge ≥ 4 clk.
  - Last edge to `cs` high ≥ 4 clk.
- `tx_ready` reasserts the cycle after a load that consumed the held word.

## Configuration
- `SPI_SLAVE_TX_UNDERRUN_EN` defined: `tx_underrun` pulses for 1 clk on any word load that finds the holding register empty, in the same cycle as the all-zeros load.
- Not defined: `tx_underrun` is tied to 0 and the detection logic is not built. Data behaviour is identical in both builds.

## Test plan
- Mode 0 (cpol=0, cpha=0), `tx_data`=0xA5 preloaded, master sends 0x3C with half-period 4 clk -> `rx_data`=0x3C with a single `rx_valid` pulse; master receives 0xA5.
- Modes 1, 2, 3 each: master sends 0xAA with slave `tx_data`=0x55 -> `rx_data`=0xAA; master receives 0x55; `miso`=0 when `cs` high.
- Back-to-back: master sends 0x12, 0x34 in one `cs` low; slave holding register refilled to 0x81 after the first load -> two `rx_valid` pulses (0x12, 0x34); master receives the preloaded word, then 0x81.
- Abort: `cs` high after 5 edges of 0xFF -> no `rx_valid`; the next full word 0x0F gives `rx_data`=0x0F.
- No held tx word at `cs` falling -> master receives 0x00; `tx_underrun` pulses once with the macro, stays 0 without it.
- `rst_n` low mid-word -> all outputs return to reset values asynchronously; the next frame after release is received correctly.

Source files
------------

// File: rtl/spi_slave_cpol_cpha.sv
// SPI responder with runtime CPOL/CPHA, MSB-first words, back-to-back words per cs assertion.
// Build macro SPI_SLAVE_TX_UNDERRUN_EN enables the tx_underrun pulse; without it the port is tied low.
module spi_slave_cpol_cpha #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;

    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  tx_idx;
    logic              miso_q;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, cs_fall, word_done, load, tx_accept;
    logic [DATA_W-1:0] load_word;

    // NOTE: the synchronizers reset to the idle bus levels so no phantom edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= cpol;
            sclk_sync <= cpol;
            sclk_prev <= cpol;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = ~cs_sync & (cpha ? trail_edge : lead_edge);
    assign shift_edge  = ~cs_sync & (cpha ? lead_edge : trail_edge);
    assign cs_fall     = ~cs_sync & cs_prev;
    assign word_done   = sample_edge & (bit_cnt == LAST_BIT);
    assign load        = cs_fall | word_done;
    assign load_word   = hold_valid ? hold_data : '0;
    assign tx_accept   = tx_valid & tx_ready;
    assign rx_next     = {rx_shift, mosi_sync};

    // The bit on the wire is indexed by samples taken so far, so the shift edge that
    // follows a cpha=0 reload re-presents the new MSB instead of skipping it.
    assign tx_idx = LAST_BIT - bit_cnt;

    // A load and an accept never both touch hold_valid: accept needs an empty holder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (tx_accept) begin
            hold_valid <= 1'b1;
            hold_data  <= tx_data;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (cs_sync) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso_q   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sample_edge) begin
                rx_shift <= rx_next[DATA_W-2:0];
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (load) begin
                tx_shift <= load_word;
                if (!cpha) begin
                    miso_q <= load_word[DATA_W-1];
                end
            end else if (shift_edge) begin
                miso_q <= tx_shift[tx_idx];
            end
        end
    end

    assign miso     = miso_q & ~cs_sync;
    assign tx_ready = ~hold_valid;
    assign busy     = ~cs_sync;

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    assign tx_underrun = load & ~hold_valid;
`else
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_cpol_cpha.sv
// Randomized scoreboard bench for spi_slave_cpol_cpha: a bench-side SPI master drives frames,
// a word-level model predicts rx words, miso words and underrun pulses.
module tb_spi_slave_cpol_cpha;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;

    spi_slave_cpol_cpha #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Word-level reference: one holding slot, every load empties it (zeros if already empty).
    bit         held_valid = 1'b0;
    logic [7:0] held_data = 8'h00;
    int         model_underruns = 0;
    int         underrun_seen = 0;
    logic [7:0] rx_exp[$];

    function automatic logic [7:0] model_load();
        logic [7:0] w;
        if (held_valid) w = held_data;
        else begin
            w = 8'h00;
            model_underruns++;
        end
        held_valid = 1'b0;
        return w;
    endfunction

    // Frame description: words to send, and per word an optional tx refill (-1 = none).
    logic [7:0] fw[$];
    int         refill[$];
    int         half = 4;

    always @(negedge clk) begin
        if (rx_valid) begin
            check("rx_expected", 32'(rx_exp.size() > 0), 32'd1);
            if (rx_exp.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
        if (tx_underrun) underrun_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_tx(input logic [7:0] d, input string name);
        bit done = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        tx_valid = 1'b0;
        check({name, "_accept"}, 32'(done), 32'd1);
        if (done) begin
            held_valid = 1'b1;
            held_data  = d;
            check({name, "_ready_low"}, 32'(tx_ready), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_miso"}, 32'(miso), 32'd0);
        check({tag, "_rst_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rst_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_rst_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_underrun"}, 32'(tx_underrun), 32'd0);
    endtask

    // Master: one cs assertion carrying fw; abort_edges > 0 stops after that many sclk edges.
    task automatic run_frame(input bit pol, input bit pha, input int abort_edges,
                             input bit do_reset, input string tag);
        logic [7:0] exp_miso[$];
        logic [7:0] got;
        int         edges = 0;
        bit         stop = 1'b0;
        int         n = fw.size();
        cpol = pol;
        cpha = pha;
        sclk = pol;
        mosi = 1'b0;
        wait_clk(4);
        check({tag, "_idle_miso"}, 32'(miso), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        cs = 1'b0;
        exp_miso.push_back(model_load());
        if (!pha) mosi = fw[0][7];
        wait_clk(2 * half);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < n && !stop; k++) begin
            got = 8'h00;
            for (int b = 7; b >= 0 && !stop; b--) begin
                // leading edge
                if (pha) mosi = fw[k][b];
                else got[b] = miso;
                sclk = ~sclk;
                edges++;
                if (!pha && b == 0) begin
                    rx_exp.push_back(fw[k]);
                    check({tag, "_miso_word"}, 32'(got), 32'(exp_miso[k]));
                    exp_miso.push_back(model_load());
                end
                if (edges == abort_edges) stop = 1'b1;
                if (!stop && b == 7 && refill[k] >= 0) push_tx(8'(refill[k]), {tag, "_refill"});
                wait_clk(half);
                if (stop) break;
                // trailing edge
                if (pha) got[b] = miso;
                else mosi = (b > 0) ? fw[k][b-1] : ((k + 1 < n) ? fw[k+1][7] : 1'b0);
                sclk = ~sclk;
                edges++;
                if (pha && b == 0) begin
                    rx_exp.push_back(fw[k]);
                    check({tag, "_miso_word"}, 32'(got), 32'(exp_miso[k]));
                    exp_miso.push_back(model_load());
                end
                if (edges == abort_edges) stop = 1'b1;
                wait_clk(half);
            end
        end
        wait_clk(half);
        if (do_reset) begin
            #4;
            rst_n = 1'b0;
            #1;
            check_reset_outputs(tag);
            cs = 1'b1;
            sclk = pol;
            mosi = 1'b0;
            held_valid = 1'b0;
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(4);
        end else begin
            cs = 1'b1;
            wait_clk(4);
            check({tag, "_cs_high_miso"}, 32'(miso), 32'd0);
            sclk = pol;
            mosi = 1'b0;
            wait_clk(4);
        end
        check({tag, "_rx_drained"}, 32'(rx_exp.size()), 32'd0);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check({tag, "_underruns"}, 32'(underrun_seen), 32'(model_underruns));
`else
        check({tag, "_underruns"}, 32'(underrun_seen), 32'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        wait_clk(2);
        check_reset_outputs("init");
        rst_n = 1'b1;
        wait_clk(4);

        // Mode 0 baseline.
        half = 4;
        push_tx(8'hA5, "m0_pre");
        fw = '{8'h3C};
        refill = '{-1};
        run_frame(1'b0, 1'b0, 0, 1'b0, "mode0");

        // Modes 1..3.
        for (int m = 1; m < 4; m++) begin
            push_tx(8'h55, $sformatf("m%0d_pre", m));
            fw = '{8'hAA};
            refill = '{-1};
            run_frame(m[1], m[0], 0, 1'b0, $sformatf("mode%0d", m));
        end

        // Back-to-back words with a refill after the first load.
        push_tx(8'h5A, "b2b_pre");
        fw = '{8'h12, 8'h34};
        refill = '{8'h81, -1};
        run_frame(1'b0, 1'b0, 0, 1'b0, "b2b");

        // Mid-word abort, then a clean word.
        fw = '{8'hFF};
        refill = '{-1};
        run_frame(1'b0, 0, 5, 1'b0, "abort");
        fw = '{8'h0F};
        refill = '{-1};
        run_frame(1'b0, 1'b0, 0, 1'b0, "after_abort");

        // Nothing held: zeros go out.
        fw = '{8'hC3};
        refill = '{-1};
        run_frame(1'b1, 1'b1, 0, 1'b0, "empty_tx");

        // Reset mid-word, then a normal frame.
        push_tx(8'h3E, "rst_pre");
        fw = '{8'h96};
        refill = '{-1};
        run_frame(1'b0, 1'b1, 7, 1'b1, "midreset");
        push_tx(8'h71, "post_pre");
        fw = '{8'hE4};
        refill = '{-1};
        run_frame(1'b0, 1'b1, 0, 1'b0, "post_reset");

        // Randomized frames.
        for (int r = 0; r < 12; r++) begin
            half = $urandom_range(6, 4);
            nw = $urandom_range(3, 1);
            fw.delete();
            refill.delete();
            for (int k = 0; k < nw; k++) begin
                fw.push_back(8'($urandom));
                refill.push_back(($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : -1);
            end
            if (!held_valid && $urandom_range(3, 0) != 0) push_tx(8'($urandom), $sformatf("rnd%0d_pre", r));
            run_frame(1'($urandom), 1'($urandom), 0, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
